// File: rtl/re_k_pkg.sv
// Shared types and defaults for the k-calc flow controller.
package re_k_pkg;

  localparam int unsigned PIPE_LAT_DEF     = 8;
  localparam int unsigned TENSOR_WIDTH_DEF = 14;
  localparam int unsigned CNT_W_DEF        = 20;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // States in which new samples may enter the core
  function automatic logic state_takes_input(input state_t s);
    return (s == ST_IDLE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/re_k_vld_pipe.sv
// Valid/last tag pipeline that tracks samples through the k-calc core.
module re_k_vld_pipe
  import re_k_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic in_vld,
  input  logic in_last,
  output logic out_vld,
  output logic out_last
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] last_q;

  // Shift tags one stage whenever the core advances; reset empties the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv) begin
      vld_q[0]  <= in_vld;
      last_q[0] <= in_last;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_last = last_q[DEPTH-1];

endmodule

// File: rtl/re_k_ctrl.sv
// Flow controller around the k-calc core: frame FSM, stall control, pixel count.
module re_k_ctrl
  import re_k_pkg::*;
#(
  parameter int unsigned TENSOR_WIDTH = TENSOR_WIDTH_DEF,
  parameter int unsigned PIPE_LAT     = PIPE_LAT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    core_en,
  input  logic [TENSOR_WIDTH-1:0] core_k,
  output logic [TENSOR_WIDTH-1:0] out_k,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic                    busy,
  output logic [CNT_W-1:0]        pix_count
);

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             pipe_vld;
  logic             pipe_last;
  logic [CNT_W-1:0] pix_count_q;

  // Tag pipeline mirrors the core depth so tags line up with core_k
  re_k_vld_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_vld_pipe (
    .clk      (clk),
    .rst      (rst),
    .adv      (core_en),
    .in_vld   (accept),
    .in_last  (in_last && accept),
    .out_vld  (pipe_vld),
    .out_last (pipe_last)
  );

  // Whole pipeline freezes only when the head sample cannot leave
  assign core_en    = !(pipe_vld && !out_ready);
  assign in_ready   = core_en && state_takes_input(state);
  assign accept     = in_valid && in_ready;

  assign out_valid  = pipe_vld;
  assign out_last   = pipe_last;
  assign out_k      = core_k;

  assign frame_done = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign pix_count  = pix_count_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: input phase, drain phase, one-cycle done
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && in_last) begin
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pipe_vld && out_ready && pipe_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Pixel counter: counts accepts, cleared as the frame retires
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count_q <= '0;
    end else if (state == ST_DONE) begin
      pix_count_q <= '0;
    end else if (accept) begin
      pix_count_q <= pix_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_re_k_ctrl.sv
// Scoreboard bench for re_k_ctrl with a behavioural pass-through k core.
module tb_re_k_ctrl;

  localparam int unsigned TW  = 14;
  localparam int unsigned LAT = 8;
  localparam int unsigned CW  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          core_en;
  logic [TW-1:0] core_k;
  logic [TW-1:0] out_k;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          frame_done;
  logic          busy;
  logic [CW-1:0] pix_count;
  logic [TW-1:0] in_data;

  always #5 clk = ~clk;

  re_k_ctrl #(
    .TENSOR_WIDTH (TW),
    .PIPE_LAT     (LAT),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .core_en    (core_en),
    .core_k     (core_k),
    .out_k      (out_k),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .busy       (busy),
    .pix_count  (pix_count)
  );

  // Core stand-in: LAT-stage data delay sharing the controller's enable
  logic [TW-1:0] cpipe [LAT];
  always @(posedge clk) begin
    if (core_en) begin
      cpipe[0] <= in_data;
      for (int i = 1; i < int'(LAT); i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign core_k = cpipe[LAT-1];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int out_cnt, fd_cnt, stall_cnt, first_acc, first_out;
  logic [TW:0]   sb [$];
  logic          hold_pend = 1'b0;
  logic [TW-1:0] hold_k    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    out_cnt   = 0;
    fd_cnt    = 0;
    stall_cnt = 0;
    first_acc = -1;
    first_out = -1;
  endtask

  // Monitor: push on accept, pop and compare on output handshake
  always @(negedge clk) begin
    logic [TW:0] exp_e;
    if (rst) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back({in_last, in_data});
        if (first_acc < 0) first_acc = cyc;
      end
      chk("core_en_rule", 32'(core_en), 32'(!(out_valid && !out_ready)));
      if (!core_en) stall_cnt++;
      if (hold_pend) begin
        chk("stall_out_valid", 32'(out_valid), 32'(1));
        chk("stall_out_k", 32'(out_k), 32'(hold_k));
      end
      hold_pend = out_valid && !out_ready;
      hold_k    = out_k;
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        out_cnt++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_out: out_valid with no pending sample, out_k=%0d", out_k);
        end else begin
          exp_e = sb.pop_front();
          chk("out_k", 32'(out_k), 32'(exp_e[TW-1:0]));
          chk("out_last", 32'(out_last), 32'(exp_e[TW]));
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  // Present one sample and hold it until accepted
  task automatic send(input logic [TW-1:0] k, input logic last);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = k;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for frame_done, check counts around it and the return to IDLE
  task automatic wait_done(input int exp_pix);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 300);
    if (!frame_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: frame_done never rose, expected 1");
    end else begin
      chk("done_pix_count", 32'(pix_count), 32'(exp_pix));
      chk("done_in_ready", 32'(in_ready), 32'(0));
      chk("done_busy", 32'(busy), 32'(1));
      @(negedge clk);
      chk("post_done_pulse", 32'(frame_done), 32'(0));
      chk("post_done_pix", 32'(pix_count), 32'(0));
      chk("post_done_busy", 32'(busy), 32'(0));
    end
  endtask

  task automatic frame16(input logic [TW-1:0] base);
    clear_stats();
    for (int i = 0; i < 16; i++) send(base + TW'(i), (i == 15));
    idle();
    wait_done(16);
    chk("f16_out_cnt", 32'(out_cnt), 32'(16));
    chk("f16_done_cnt", 32'(fd_cnt), 32'(1));
    chk("f16_latency", 32'(first_out - first_acc), 32'(LAT));
    chk("f16_sb_empty", 32'(sb.size()), 32'(0));
  endtask

  logic ov [24];

  initial begin
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_core_en", 32'(core_en), 32'(1));
    chk("rst_pix_count", 32'(pix_count), 32'(0));

    // 16-pixel frame, downstream always ready
    frame16(14'h0100);

    // Single-pixel frame straight into FLUSH
    clear_stats();
    send(14'h03A5, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = 14'h0111;
    @(negedge clk);
    chk("single_busy", 32'(busy), 32'(1));
    chk("single_in_ready", 32'(in_ready), 32'(0));
    chk("single_pix", 32'(pix_count), 32'(1));
    idle();
    wait_done(1);
    chk("single_out_cnt", 32'(out_cnt), 32'(1));
    chk("single_done_cnt", 32'(fd_cnt), 32'(1));
    chk("single_latency", 32'(first_out - first_acc), 32'(LAT));

    // 10-pixel frame with out_ready low on cycles 10..14
    clear_stats();
    fork
      begin
        for (int i = 0; i < 10; i++) send(14'h0200 + TW'(i * 7), (i == 9));
        idle();
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk); #1;
          out_ready = !(i >= 10 && i <= 14);
        end
      end
    join
    wait_done(10);
    chk("stall_cycles", 32'(stall_cnt), 32'(5));
    chk("stall_out_cnt", 32'(out_cnt), 32'(10));
    chk("stall_done_cnt", 32'(fd_cnt), 32'(1));

    // Alternating in_valid: out_valid follows the same pattern LAT later
    clear_stats();
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 8) && (i % 2 == 0);
      in_last  = (i == 6);
      in_data  = TW'(300 + i);
      @(negedge clk);
      ov[i] = out_valid;
    end
    idle();
    for (int i = 0; i < 16; i++) chk("toggle_out_valid", 32'(ov[i+8]), 32'((i < 8) && (i % 2 == 0)));
    chk("toggle_out_cnt", 32'(out_cnt), 32'(4));
    chk("toggle_done_cnt", 32'(fd_cnt), 32'(1));

    // Reset in the middle of a 12-pixel frame
    clear_stats();
    for (int i = 0; i < 5; i++) send(14'h0400 + TW'(i), 1'b0);
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_pix", 32'(pix_count), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 8; i++) begin
      chk("midrst_no_out", 32'(out_valid), 32'(0));
      @(negedge clk);
    end
    frame16(14'h0500);

    // in_last without in_valid while in RUN
    clear_stats();
    for (int i = 0; i < 3; i++) send(14'h0600 + TW'(i), 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ghost_last_busy", 32'(busy), 32'(1));
      chk("ghost_last_in_ready", 32'(in_ready), 32'(1));
      chk("ghost_last_pix", 32'(pix_count), 32'(3));
    end
    send(14'h0603, 1'b1);
    idle();
    wait_done(4);
    chk("ghost_out_cnt", 32'(out_cnt), 32'(4));
    chk("ghost_sb_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/re_k_ctrl.md
RE_K_CTRL -- requirements
Module: re_k_ctrl

Interface
REQ-001 SHALL have parameter TENSOR_WIDTH, default 14: width of k sample.
REQ-002 SHALL have parameter PIPE_LAT, default 8: cycles from core_en-qualified input capture to core_k valid (6 core stages + 2 divide_and_round).
REQ-003 SHALL have parameter CNT_W, default 20: pixel counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream tensor/velocity sample present.
REQ-007 SHALL have port in_last  input  1  sample is last pixel of frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  sample accepted this cycle when in_valid && in_ready.
REQ-009 SHALL have port core_en  output  1  enable to k-calc core and its divide/round stage.
REQ-010 SHALL have port core_k  input  TENSOR_WIDTH  registered k from core.
REQ-011 SHALL have port out_k  output  TENSOR_WIDTH  k to downstream, equal to core_k.
REQ-012 SHALL have port out_valid  output  1  out_k valid.
REQ-013 SHALL have port out_last  output  1  out_k is last pixel of frame.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after last output accepted.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port pix_count  output  CNT_W  accepted pixels in current frame.

Function
REQ-018 SHALL keep a PIPE_LAT-deep valid/last shift register; advances only when core_en is high; stage 0 loads accept and in_last&&accept.
REQ-019 SHALL drive core_en = !(vld[PIPE_LAT-1] && !out_ready); whole pipeline stalls together, no sample dropped or duplicated.
REQ-020 SHALL drive out_valid = vld[PIPE_LAT-1], out_last = last[PIPE_LAT-1], out_k = core_k combinationally.
REQ-021 SHALL drive in_ready = core_en && state in {IDLE, RUN}.
REQ-022 SHALL implement FSM IDLE, RUN, FLUSH, DONE.
REQ-023 IDLE -> RUN on accept without in_last; IDLE -> FLUSH on accept with in_last (single-pixel frame).
REQ-024 RUN -> FLUSH on accept with in_last; otherwise stay.
REQ-025 FLUSH: in_ready low, core_en per REQ-019; -> DONE when out_valid && out_ready && out_last.
REQ-026 DONE: frame_done high exactly this cycle, in_ready low; -> IDLE unconditionally next cycle.
REQ-027 pix_count SHALL increment by 1 per accept, clear on entry to IDLE from DONE, wrap modulo 2^CNT_W.
REQ-028 Throughput SHALL be one sample per cycle with out_ready held high; latency in_valid accept -> out_valid = PIPE_LAT cycles.
REQ-029 out_valid SHALL never be high with no sample accepted; out_valid held and out_k stable while out_ready low.
REQ-030 in_last on a non-accepted cycle SHALL be ignored.

Reset
REQ-031 On rst: state IDLE, vld and last all 0, pix_count 0; out_valid, out_last, frame_done, busy 0; in_ready and core_en 1.
REQ-032 rst mid-frame SHALL discard all in-flight samples; no out_valid until new samples accepted and PIPE_LAT elapse.

Structure
REQ-033 Package re_k_pkg SHALL hold state enum and default PIPE_LAT constant.
REQ-034 Valid/last shift register SHALL be sub-module re_k_vld_pipe (params DEPTH; ports clk, rst, adv, in_vld, in_last, out_vld, out_last).
REQ-035 Core and divide_and_round SHALL remain outside; data buses route source -> core directly, only control passes through this block.

Verification
REQ-036 Reset, then 16-pixel frame, out_ready=1: out_valid first at cycle 8 after first accept, 16 outputs, out_last on 16th, frame_done one cycle later, pix_count=16 before clear.
REQ-037 Single pixel with in_last from IDLE: FLUSH entered, in_ready low until DONE, exactly one output with out_last, one frame_done pulse.
REQ-038 10-pixel frame, out_ready low cycles 10-14: core_en low exactly while out_valid && !out_ready, out_k stable, all 10 k values delivered in order.
REQ-039 in_valid toggling 1,0,1,0: out_valid pattern identical, delayed 8 cycles.
REQ-040 rst pulsed at pixel 5 of 12-pixel frame: zero outputs for next 8 cycles, state IDLE, pix_count 0, next frame behaves as REQ-036.
REQ-041 in_last asserted with in_valid=0 in RUN: no FSM transition, pix_count unchanged.
